// File: rtl/prbs_burst_ctrl_if.sv
// prbs_burst_ctrl_if
//   Bundles the controller's link to the LFSR datapath and its framed
//   serial output stream.
//   LFSR side : lfsr_load, lfsr_seed[30:0], lfsr_poly[1:0], lfsr_en
//               (controller -> generator), lfsr_bit (generator -> controller)
//   Stream    : tx_bit, tx_valid, tx_sop, tx_eop (controller -> pins)
//   master = controller, slave = generator / stream consumer.
interface prbs_burst_ctrl_if;
  logic        lfsr_load;
  logic [30:0] lfsr_seed;
  logic [1:0]  lfsr_poly;
  logic        lfsr_en;
  logic        lfsr_bit;
  logic        tx_bit;
  logic        tx_valid;
  logic        tx_sop;
  logic        tx_eop;

  modport master (
    output lfsr_load, lfsr_seed, lfsr_poly, lfsr_en,
    output tx_bit, tx_valid, tx_sop, tx_eop,
    input  lfsr_bit
  );

  modport slave (
    input  lfsr_load, lfsr_seed, lfsr_poly, lfsr_en,
    input  tx_bit, tx_valid, tx_sop, tx_eop,
    output lfsr_bit
  );
endinterface

// File: rtl/prbs_burst_ctrl.sv
// prbs_burst_ctrl
//   Sequencing controller for the on-chip PRBS generator. Loads seed and
//   polynomial select, emits a fixed preamble, steps the generator for
//   burst_len bits, repeats bursts separated by idle gaps and supports
//   single-bit error injection.
// Ports:
//   clk, rst_n       clock; reset (asynchronous, active-high)
//   start, abort     sequence control (abort wins, start sampled in IDLE)
//   poly_sel, seed, burst_len, gap_len, repeat_cnt
//                    configuration, latched when a sequence starts
//   inject           request one inverted PRBS bit
//   bus              LFSR datapath link and framed output stream
//   busy, done       status (done pulses for one cycle on completion)
//   burst_idx        0-based index of the current burst
module prbs_burst_ctrl #(
  parameter logic [7:0]  PREAMBLE = 8'hA5,
  parameter int unsigned LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       poly_sel,
  input  logic [30:0]      seed,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [7:0]       gap_len,
  input  logic [7:0]       repeat_cnt,
  input  logic             inject,
  prbs_burst_ctrl_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [7:0]       burst_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRE,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [2:0]       pre_cnt;
  logic [LEN_W-1:0] run_cnt;
  logic [7:0]       gap_cnt;

  logic [LEN_W-1:0] len_q;
  logic [7:0]       gap_q;
  logic [7:0]       rep_q;
  logic [30:0]      seed_q;
  logic [1:0]       poly_q;
  logic             load_q;
  logic             inj_pend;

  logic [30:0]      seed_mask;
  logic [30:0]      seed_adj;

  logic pre_last;
  logic run_last;
  logic gap_last;

  logic tx_bit_c;
  logic tx_valid_c;
  logic tx_sop_c;
  logic tx_eop_c;
  logic lfsr_en_c;

  assign pre_last = (pre_cnt == 3'd7);
  assign run_last = (run_cnt == len_q - LEN_W'(1));
  assign gap_last = (gap_cnt == gap_q - 8'd1);

  // Seed conditioning: never hand the generator an all-zero state, either
  // from a zero seed or from bits that fall outside the selected width.
  always_comb begin
    seed_mask = 31'h7FFF_FFFF;
    case (poly_sel)
      2'd0:    seed_mask = 31'h0000_007F;
      2'd1:    seed_mask = 31'h0000_7FFF;
      2'd2:    seed_mask = 31'h007F_FFFF;
      default: seed_mask = 31'h7FFF_FFFF;
    endcase
    seed_adj = ((seed == '0) ? 31'd1 : seed) & seed_mask;
    if (seed_adj == '0) begin
      seed_adj = 31'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tx_bit_c   = 1'b0;
    tx_valid_c = 1'b0;
    tx_sop_c   = 1'b0;
    tx_eop_c   = 1'b0;
    lfsr_en_c  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && (burst_len != '0)) begin
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        next_state = S_PRE;
      end
      S_PRE: begin
        tx_valid_c = 1'b1;
        tx_bit_c   = PREAMBLE[3'd7 - pre_cnt];
        tx_sop_c   = (pre_cnt == 3'd0);
        if (pre_last) begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        tx_valid_c = 1'b1;
        lfsr_en_c  = 1'b1;
        tx_bit_c   = bus.lfsr_bit ^ inj_pend;
        tx_eop_c   = run_last;
        if (run_last) begin
          if (burst_idx < rep_q) begin
            next_state = (gap_q == 8'd0) ? S_PRE : S_GAP;
          end else begin
            next_state = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (gap_last) begin
          next_state = S_PRE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase

    if (abort) begin
      next_state = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pre_cnt   <= '0;
      run_cnt   <= '0;
      gap_cnt   <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      rep_q     <= '0;
      seed_q    <= 31'd1;
      poly_q    <= 2'd3;
      load_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      burst_idx <= '0;
      inj_pend  <= 1'b0;
    end else begin
      // Status flags are registered from next_state so they line up with
      // the state they describe.
      load_q <= (next_state == S_LOAD);
      busy   <= (next_state inside {S_LOAD, S_PRE, S_RUN, S_GAP});
      done   <= (next_state == S_DONE);

      // Counters run only inside their own state and sit at zero otherwise,
      // so every PRE/RUN/GAP entry starts from a clean count.
      pre_cnt <= (state == S_PRE) ? pre_cnt + 3'd1 : '0;
      run_cnt <= ((state == S_RUN) && !run_last) ? run_cnt + LEN_W'(1) : '0;
      gap_cnt <= ((state == S_GAP) && !gap_last) ? gap_cnt + 8'd1 : '0;

      if ((state == S_IDLE) && (next_state == S_LOAD)) begin
        len_q     <= burst_len;
        gap_q     <= gap_len;
        rep_q     <= repeat_cnt;
        seed_q    <= seed_adj;
        poly_q    <= poly_sel;
        burst_idx <= '0;
      end

      if ((next_state == S_PRE) && ((state == S_RUN) || (state == S_GAP))) begin
        burst_idx <= burst_idx + 8'd1;
      end

      // A pending request is consumed by the first RUN bit that sees it;
      // a request arriving in that same cycle merges into it.
      if (abort || (state == S_IDLE) || (state == S_DONE)) begin
        inj_pend <= 1'b0;
      end else if ((state == S_RUN) && inj_pend) begin
        inj_pend <= 1'b0;
      end else if (inject && busy) begin
        inj_pend <= 1'b1;
      end
    end
  end

  assign bus.lfsr_load = load_q;
  assign bus.lfsr_seed = seed_q;
  assign bus.lfsr_poly = poly_q;
  assign bus.lfsr_en   = lfsr_en_c;
  assign bus.tx_bit    = tx_bit_c;
  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_sop    = tx_sop_c;
  assign bus.tx_eop    = tx_eop_c;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// tb_prbs_burst_ctrl
//   Directed bench for prbs_burst_ctrl. Includes a behavioural LFSR
//   generator that answers lfsr_load/lfsr_en, and an independent reference
//   LFSR seeded with the expected seed and stepped once per expected RUN bit.
module tb_prbs_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  poly_sel = '0;
  logic [30:0] seed = '0;
  logic [15:0] burst_len = '0;
  logic [7:0]  gap_len = '0;
  logic [7:0]  repeat_cnt = '0;
  logic        inject = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  burst_idx;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  logic [30:0] gen = 31'd1;
  logic [1:0]  gen_poly = 2'd0;
  logic [30:0] ref_s;
  logic        pre_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  prbs_burst_ctrl_if bus();

  prbs_burst_ctrl #(.PREAMBLE(8'hA5), .LEN_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .poly_sel   (poly_sel),
    .seed       (seed),
    .burst_len  (burst_len),
    .gap_len    (gap_len),
    .repeat_cnt (repeat_cnt),
    .inject     (inject),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .burst_idx  (burst_idx)
  );

  function automatic logic prbs_out(input logic [30:0] s, input logic [1:0] p);
    case (p)
      2'd0:    return s[6];
      2'd1:    return s[14];
      2'd2:    return s[22];
      default: return s[30];
    endcase
  endfunction

  function automatic logic [30:0] prbs_step(input logic [30:0] s, input logic [1:0] p);
    logic fb;
    case (p)
      2'd0:    fb = s[6] ^ s[5];
      2'd1:    fb = s[14] ^ s[13];
      2'd2:    fb = s[22] ^ s[17];
      default: fb = s[30] ^ s[27];
    endcase
    return {s[29:0], fb};
  endfunction

  // Behavioural generator on the slave side of the link.
  always @(posedge clk) begin
    if (bus.lfsr_load) begin
      gen      <= bus.lfsr_seed;
      gen_poly <= bus.lfsr_poly;
    end else if (bus.lfsr_en) begin
      gen <= prbs_step(gen, gen_poly);
    end
  end
  assign bus.lfsr_bit = prbs_out(gen, gen_poly);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one edge; on return the bench sits in cycle 1 (LOAD).
  task automatic start_seq(input logic [1:0] p, input logic [30:0] s,
                           input logic [15:0] len, input logic [7:0] gap,
                           input logic [7:0] rep);
    poly_sel   = p;
    seed       = s;
    burst_len  = len;
    gap_len    = gap;
    repeat_cnt = rep;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned p;
    int unsigned b;
    logic        exp_run;
    logic        seen;

    // Reset values while reset is held
    repeat (3) @(posedge clk);
    #1;
    check("rst_seed", bus.lfsr_seed, 31'd1);
    check("rst_poly", bus.lfsr_poly, 2'd3);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", bus.tx_valid, 1'b0);
    check("rst_load", bus.lfsr_load, 1'b0);
    check("rst_idx", burst_idx, 8'd0);
    rst_n = 1'b0;
    tick();

    // Single PRBS7 burst, L=20
    ref_s = 31'd1;
    start_seq(2'd0, 31'd1, 16'd20, 8'd0, 8'd0);
    check("t1_load", bus.lfsr_load, 1'b1);
    check("t1_busy", busy, 1'b1);
    check("t1_seed", bus.lfsr_seed, 31'd1);
    check("t1_poly", bus.lfsr_poly, 2'd0);
    check("t1_valid_load", bus.tx_valid, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t1_pre_valid", bus.tx_valid, 1'b1);
      check("t1_pre_bit", bus.tx_bit, pre_bits[k]);
      check("t1_pre_sop", bus.tx_sop, (k == 0));
      check("t1_pre_en", bus.lfsr_en, 1'b0);
      check("t1_pre_load", bus.lfsr_load, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t1_run_valid", bus.tx_valid, 1'b1);
      check("t1_run_en", bus.lfsr_en, 1'b1);
      check("t1_run_bit", bus.tx_bit, prbs_out(ref_s, 2'd0));
      check("t1_run_eop", bus.tx_eop, (i == 19));
      check("t1_run_done", done, 1'b0);
      ref_s = prbs_step(ref_s, 2'd0);
    end
    tick();
    check("t1_done", done, 1'b1);
    check("t1_done_busy", busy, 1'b0);
    check("t1_done_valid", bus.tx_valid, 1'b0);
    tick();
    check("t1_done_pulse", done, 1'b0);

    // inject while idle must be dropped
    inject = 1'b1;
    tick();
    inject = 1'b0;

    // Three bursts, L=4, gap=3; config inputs scrambled after start
    ref_s = 31'd1;
    start_seq(2'd0, 31'd1, 16'd4, 8'd3, 8'd2);
    burst_len  = 16'd99;
    gap_len    = 8'd0;
    repeat_cnt = 8'd0;
    seed       = 31'h55;
    check("t2_load", bus.lfsr_load, 1'b1);
    for (int cyc = 2; cyc <= 44; cyc++) begin
      tick();
      if (cyc == 44) begin
        check("t2_done", done, 1'b1);
        check("t2_done_busy", busy, 1'b0);
        check("t2_done_valid", bus.tx_valid, 1'b0);
      end else begin
        p = (cyc - 2) % 15;
        b = (cyc - 2) / 15;
        exp_run = (p >= 8) && (p < 12);
        check("t2_sop", bus.tx_sop, (p == 0));
        check("t2_valid", bus.tx_valid, (p < 12));
        check("t2_en", bus.lfsr_en, exp_run);
        check("t2_eop", bus.tx_eop, (p == 11));
        check("t2_idx", burst_idx, b);
        check("t2_busy", busy, 1'b1);
        check("t2_nodone", done, 1'b0);
        if (exp_run) begin
          check("t2_run_bit", bus.tx_bit, prbs_out(ref_s, 2'd0));
          ref_s = prbs_step(ref_s, 2'd0);
        end
      end
    end
    tick();

    // Injection: two requests in PRE collapse into one flipped bit
    ref_s = 31'd1;
    start_seq(2'd0, 31'd1, 16'd10, 8'd0, 8'd0);
    tick();
    tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_run_en", bus.lfsr_en, 1'b1);
      check("t3_run_bit", bus.tx_bit, prbs_out(ref_s, 2'd0) ^ (i == 0));
      ref_s = prbs_step(ref_s, 2'd0);
    end
    tick();
    check("t3_done", done, 1'b1);
    tick();

    // Abort in the third RUN cycle together with start
    start_seq(2'd0, 31'd1, 16'd20, 8'd0, 8'd0);
    repeat (11) tick();
    check("t4_in_run", bus.lfsr_en, 1'b1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("t4_busy", busy, 1'b0);
    check("t4_valid", bus.tx_valid, 1'b0);
    check("t4_en", bus.lfsr_en, 1'b0);
    check("t4_done", done, 1'b0);
    check("t4_load", bus.lfsr_load, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      seen = seen | done | bus.lfsr_load | busy;
    end
    check("t4_quiet", seen, 1'b0);

    // abort beats start in IDLE
    burst_len = 16'd20;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t4_idle_load", bus.lfsr_load, 1'b0);
    check("t4_idle_busy", busy, 1'b0);

    // burst_len=0 is ignored
    start_seq(2'd0, 31'd1, 16'd0, 8'd0, 8'd0);
    check("t5_len0_load", bus.lfsr_load, 1'b0);
    check("t5_len0_busy", busy, 1'b0);
    tick();
    check("t5_len0_busy2", busy, 1'b0);

    // Seed conditioning vectors
    start_seq(2'd3, 31'd0, 16'd5, 8'd0, 8'd0);
    check("t5_seed0", bus.lfsr_seed, 31'd1);
    check("t5_seed0_poly", bus.lfsr_poly, 2'd3);
    abort = 1'b1; tick(); abort = 1'b0;
    start_seq(2'd0, 31'h0000_0080, 16'd5, 8'd0, 8'd0);
    check("t5_seed_mask0", bus.lfsr_seed, 31'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    start_seq(2'd1, 31'h1234_5678, 16'd5, 8'd0, 8'd0);
    check("t5_seed_p15", bus.lfsr_seed, 31'h0000_5678);
    check("t5_poly_p15", bus.lfsr_poly, 2'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    start_seq(2'd2, 31'h7FFF_FFFF, 16'd5, 8'd0, 8'd0);
    check("t5_seed_p23", bus.lfsr_seed, 31'h007F_FFFF);
    abort = 1'b1; tick(); abort = 1'b0;

    // Asynchronous reset in the middle of RUN
    start_seq(2'd0, 31'd5, 16'd20, 8'd3, 8'd4);
    repeat (11) tick();
    check("t6_in_run", bus.tx_valid, 1'b1);
    #2;
    rst_n = 1'b1;
    #1;
    check("t6_valid", bus.tx_valid, 1'b0);
    check("t6_en", bus.lfsr_en, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_idx", burst_idx, 8'd0);
    check("t6_seed", bus.lfsr_seed, 31'd1);
    check("t6_poly", bus.lfsr_poly, 2'd3);
    tick();
    rst_n = 1'b0;
    tick();
    check("t6_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_burst_ctrl.md
# prbs_burst_ctrl

Sequencing controller for the on-chip PRBS generator. It loads a seed and polynomial select, steps the generator for a programmed number of bits, and frames each burst with a fixed preamble. It also repeats bursts with idle gaps and supports single-bit error injection. It sits between the configuration inputs and the LFSR datapath, and produces a framed serial test stream for the output pins.

## Interface
Parameters:
- PREAMBLE, 8'hA5: preamble pattern sent MSB first before every burst.
- LEN_W, 16: width of the burst length counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- start  in  1  begin sequence; sampled only in IDLE
- abort  in  1  terminate sequence from any state
- poly_sel  in  2  0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31; latched at start
- seed  in  31  LFSR seed; latched at start
- burst_len  in  LEN_W  PRBS bits per burst; latched at start
- gap_len  in  8  idle cycles between bursts; latched at start
- repeat_cnt  in  8  number of bursts minus one; latched at start
- inject  in  1  request one inverted bit
- lfsr_bit  in  1  current output bit of the generator
- lfsr_load  out  1  load lfsr_seed into the generator this cycle
- lfsr_seed  out  31  seed to load
- lfsr_poly  out  2  polynomial select to the generator
- lfsr_en  out  1  advance the generator at the end of this cycle
- tx_bit  out  1  serial stream bit
- tx_valid  out  1  tx_bit is meaningful
- tx_sop  out  1  first preamble bit of a burst
- tx_eop  out  1  last PRBS bit of a burst
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on normal completion
- burst_idx  out  8  index of the current burst, 0-based

## Operation
- States: IDLE, LOAD, PRE, RUN, GAP, DONE.
- Reset values: state IDLE. lfsr_seed=31'd1, lfsr_poly=2'd3, burst_idx=0. All other outputs 0. Inject-pending flag cleared.
- **IDLE:**
  - start=1 with burst_len≠0 and abort=0 latches the config, sets burst_idx=0, and moves to LOAD.
  - start=1 with burst_len=0 is ignored and the block stays in IDLE.
- **Seed handling:** a seed of 0 is replaced by 31'd1. The seed is masked to the low 7/15/23/31 bits per poly_sel. If the masked value is 0, it becomes 1.
- **LOAD (1 cycle):** lfsr_load=1. Next state is PRE.
- **PRE (8 cycles):**
  - tx_valid=1 and tx_bit=PREAMBLE[7-k] for k=0..7.
  - tx_sop=1 on k=0.
  - lfsr_en=0.
- **RUN (burst_len cycles):**
  - tx_valid=1 and lfsr_en=1.
  - tx_bit = lfsr_bit XOR inject_pending.
  - tx_eop=1 on the last cycle.
- **GAP:**
  - Entered after RUN when burst_idx<repeat_cnt. Lasts gap_len cycles, or is skipped when gap_len=0.
  - tx_valid=0 and lfsr_en=0.
  - On exit, burst_idx increments and the next state is PRE.
  - The generator is not reseeded between bursts; the sequence continues.
- **DONE (1 cycle):** entered after the RUN of the last burst. done=1 and busy=0. Next state is IDLE.
- **busy:** 1 in LOAD, PRE, RUN and GAP.
- **Injection:**
  - inject=1 while busy sets inject_pending.
  - inject_pending is applied to the next RUN bit, then cleared at that cycle's end.
  - Multiple requests before use collapse into one.
  - inject in IDLE is ignored.
- **Abort:**
  - abort=1 in any state sends the block to IDLE next cycle.
  - lfsr_en, tx_valid and busy go low from that cycle; done is not pulsed.
  - inject_pending is cleared.
  - abort takes priority over start.
- **Config changes:** changes to config inputs while busy have no effect. start while busy is ignored.

## Timing
- State, counters, lfsr_load, lfsr_seed, lfsr_poly, busy and done are registered.
- tx_bit, tx_valid, tx_sop, tx_eop and lfsr_en are decoded from the registered state. In RUN, tx_bit is combinational from lfsr_bit.
- Timeline for start sampled high at edge 0:
  - Cycle 1: LOAD.
  - Cycles 2–9: PRE.
  - Cycles 10..9+L: RUN, where L=burst_len.
- Each additional burst costs gap_len+8+L cycles.
- Total cycles from start to the done pulse: 1 + (repeat_cnt+1)·(8+L) + repeat_cnt·gap_len + 1.
- Counters:
  - PRE counter: 3 bits.
  - RUN counter: LEN_W bits, compared with burst_len-1 (no wrap, since burst_len≥1).
  - GAP counter: 8 bits.
- Ports are not resynchronized; rst_n deasserts synchronously to clk at the system level.

## Test plan
- Reset mid-RUN → all outputs return to their reset values immediately; state is IDLE; burst_idx=0.
- start with poly=0, seed=1, burst_len=20, gap=0, repeat=0 → lfsr_load at cycle 1; 8 preamble bits 1,0,1,0,0,1,0,1; then 20 RUN bits matching a PRBS7 model; tx_eop at cycle 29; done at cycle 30.
- burst_len=4, gap_len=3, repeat_cnt=2 → 3 bursts with tx_sop at cycles 2, 17 and 32; burst_idx 0/1/2; the PRBS sequence is continuous across bursts; done at cycle 44.
- inject pulsed twice during PRE, burst_len=10 → exactly the first RUN bit is inverted versus the model; all other bits match.
- abort at the third RUN cycle, with start asserted in the same cycle → IDLE next cycle; busy=0; no done pulse; start is not honoured.
- start with burst_len=0 → no lfsr_load, busy stays 0. start with seed=0, poly=3 → lfsr_seed=31'd1.
